alu_datapath_sequencer: RTL
===========================

// Module: alu_datapath_sequencer
// PURPOSE
//  Multi-cycle control sequencer for the RegFile/ALU/DataMemory datapath.
//  Accepts one RV32I-subset instruction word per valid/ready handshake.
//  Decodes it into the datapath controls, then steps it through EXEC -> MEM/WB.
//  Sits between the instruction source (test harness or fetch unit) and the datapath top.
// PARAMETERS
//  A_WIDTH  5   register address width (A1/A2/A3)
//  D_WIDTH  32  data/immediate width; instruction width is fixed at 32
// PORTS
//  CLK          in   1        clock; all state updates on rising edge
//  RST          in   1        reset, synchronous, active-high
//  instr_valid  in   1        instruction word offered
//  instr_ready  out  1        sequencer can accept (state IDLE)
//  instr        in   32       instruction word
//  Zero         in   1        ALU zero flag from datapath
//  ALUSrc       out  1        0: SrcB=RD2, 1: SrcB=ImmExt
//  ALUControl   out  3        ALU op (pkg encoding)
//  RegWrite     out  1        register-file write strobe
//  MemWrite     out  1        data-memory write strobe
//  ResultSrc    out  1        0: ALUResult, 1: ReadData to WD3
//  A1,A2,A3     out  A_WIDTH  rs1, rs2, rd
//  ImmExt       out  D_WIDTH  sign-extended immediate
//  branch_taken out  1        1-cycle pulse: beq resolved with Zero=1
//  illegal      out  1        1-cycle pulse: unsupported encoding
//  busy         out  1        ~instr_ready
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except instr_ready=1. RST wins over every other event.
//  - RST mid-instruction aborts it at that edge: no RegWrite/MemWrite is issued afterwards.
//  - States: IDLE -> EXEC -> {WB | MEM | IDLE}; WB -> IDLE; MEM -> IDLE.
//  - Accept on instr_valid & instr_ready. Fields are registered at that edge.
//  - instr_valid while busy is ignored; the word must be held by the source.
//  - Supported: R add/sub/and/or/slt (0110011); I addi/andi/ori/slti (0010011);
//    lw (0000011, f3=010); sw (0100011, f3=010); beq (1100011, f3=000).
//  - Anything else is illegal: EXEC pulses illegal=1, no strobes, then IDLE.
//  - EXEC (1 cycle): A1/A2/A3, ALUSrc, ALUControl and ImmExt are valid.
//  - Those outputs are held unchanged through WB/MEM and cleared to 0 on return to IDLE.
//  - R/I/lw: WB (1 cycle), RegWrite=1, ResultSrc=1 for lw only.
//  - RegWrite is suppressed when rd==0. Latency: accept edge -> write edge = 3 edges.
//  - sw: MEM (1 cycle), MemWrite=1, ALUSrc=1, ALUControl=ADD.
//  - beq: EXEC drives ALUSrc=0, ALUControl=SUB; Zero is sampled at the EXEC edge.
//  - beq pulses branch_taken in the following (IDLE) cycle; no strobes are issued.
//  - ImmExt: I/lw = sext(instr[31:20]); sw = sext({instr[31:25],instr[11:7]}); else 0.
//  - RegWrite and MemWrite are never high in the same cycle; each is high for exactly 1 cycle per instruction.
//  - Back-to-back: instr_ready is high in the cycle after WB/MEM/EXEC-exit.
//    Minimum spacing is 3 cycles (2 for beq/illegal).
// CONFIGURATION
//  - Macro ALUSEQ_PERF_CNT_EN:
//  - When defined: adds outputs retired_cnt[31:0] and illegal_cnt[15:0].
//    retired_cnt increments once per completed legal instruction (WB/MEM exit, or EXEC exit for beq).
//    illegal_cnt increments once per illegal pulse.
//    Both counters wrap modulo 2^N and clear on RST.
//  - When undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package alu_seq_pkg holds:
//    - state_t enum {IDLE, EXEC, WB, MEM};
//    - ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101;
//    - opcode localparams; decoded-control struct ctrl_t.
//  - One sub-module, alu_seq_decoder: combinational instr -> ctrl_t plus legal flag. The FSM stays in the top.
// TESTING
//  1. addi x1,x0,5 then add x2,x1,x1
//     -> RegWrite pulses with A3=1 then A3=2; a0-side readback gives x2=10.
//  2. sw x2,8(x0) then lw x3,8(x0)
//     -> MemWrite pulse with ImmExt=8, ALUSrc=1; lw WB has ResultSrc=1 and x3=10.
//  3. beq x1,x1 -> branch_taken=1 for 1 cycle; beq x1,x2 (5 vs 10) -> no pulse. RegWrite=0 throughout.
//  4. instr=32'h0000_0000 -> illegal pulse 1 cycle later; no strobes; instr_ready high again after 2 cycles.
//  5. RST asserted during WB-bound EXEC of addi x4,x0,7 -> no RegWrite; x4 stays 0; outputs return to reset values next cycle.
//  6. addi x0,x0,9 -> no RegWrite.
//     With ALUSEQ_PERF_CNT_EN: retired_cnt increments by 1 per test instruction; illegal_cnt counts test 4.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the ALU datapath sequencer.
// Optional feature macro used by the top: ALUSEQ_PERF_CNT_EN.
package alu_seq_pkg;

  localparam int CTRL_A_W = 5;
  localparam int CTRL_D_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    MEM  = 2'd3
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Decoded controls captured at accept and replayed through EXEC/WB/MEM.
  // wb/mem select the state after EXEC; neither set on a legal word means beq.
  typedef struct packed {
    logic                alu_src;
    logic [2:0]          alu_control;
    logic                result_src;
    logic                wb;
    logic                mem;
    logic [CTRL_A_W-1:0] a1;
    logic [CTRL_A_W-1:0] a2;
    logic [CTRL_A_W-1:0] a3;
    logic [CTRL_D_W-1:0] imm;
  } ctrl_t;

  function automatic logic [CTRL_D_W-1:0] sext12(input logic [11:0] v);
    return {{(CTRL_D_W-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/alu_seq_decoder.sv
// Combinational instruction decoder: 32-bit word -> ctrl_t plus legal flag.
// Illegal words decode to an all-zero control set.
module alu_seq_decoder
  import alu_seq_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  // Field extraction and ALU op selection per supported format.
  always_comb begin
    ctrl  = '0;
    legal = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.a1 = rs1;
        ctrl.a2 = rs2;
        ctrl.a3 = rd;
        ctrl.wb = 1'b1;
        legal   = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: ctrl.alu_control = ALU_ADD;
          {F7_ALT,  F3_ADD}: ctrl.alu_control = ALU_SUB;
          {F7_BASE, F3_AND}: ctrl.alu_control = ALU_AND;
          {F7_BASE, F3_OR }: ctrl.alu_control = ALU_OR;
          {F7_BASE, F3_SLT}: ctrl.alu_control = ALU_SLT;
          default:           legal = 1'b0;
        endcase
      end
      OP_I: begin
        ctrl.a1      = rs1;
        ctrl.a3      = rd;
        ctrl.alu_src = 1'b1;
        ctrl.wb      = 1'b1;
        ctrl.imm     = sext12(instr[31:20]);
        legal        = 1'b1;
        case (funct3)
          F3_ADD:  ctrl.alu_control = ALU_ADD;
          F3_AND:  ctrl.alu_control = ALU_AND;
          F3_OR:   ctrl.alu_control = ALU_OR;
          F3_SLT:  ctrl.alu_control = ALU_SLT;
          default: legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        ctrl.a1          = rs1;
        ctrl.a3          = rd;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
        ctrl.result_src  = 1'b1;
        ctrl.wb          = 1'b1;
        ctrl.imm         = sext12(instr[31:20]);
        legal            = (funct3 == F3_W);
      end
      OP_STORE: begin
        ctrl.a1          = rs1;
        ctrl.a2          = rs2;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
        ctrl.mem         = 1'b1;
        ctrl.imm         = sext12({instr[31:25], instr[11:7]});
        legal            = (funct3 == F3_W);
      end
      OP_BRANCH: begin
        ctrl.a1          = rs1;
        ctrl.a2          = rs2;
        ctrl.alu_control = ALU_SUB;
        legal            = (funct3 == F3_BEQ);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) ctrl = '0;
  end

endmodule

// File: rtl/alu_datapath_sequencer.sv
// Multi-cycle control sequencer for the RegFile/ALU/DataMemory datapath.
// Accepts one instruction per valid/ready handshake and steps it through
// EXEC -> WB/MEM. Optional perf counters are enabled by ALUSEQ_PERF_CNT_EN.
//
// state | meaning
// IDLE  | ready for a new word, all datapath controls 0
// EXEC  | operands/ALU controls driven; beq samples Zero; illegal pulses
// WB    | register write (RegWrite unless rd==0)
// MEM   | data memory write (MemWrite)
module alu_datapath_sequencer
  import alu_seq_pkg::*;
#(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  input  logic               Zero,
  output logic               ALUSrc,
  output logic [2:0]         ALUControl,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               ResultSrc,
  output logic [A_WIDTH-1:0] A1,
  output logic [A_WIDTH-1:0] A2,
  output logic [A_WIDTH-1:0] A3,
  output logic [D_WIDTH-1:0] ImmExt,
  output logic               branch_taken,
  output logic               illegal,
  output logic               busy
`ifdef ALUSEQ_PERF_CNT_EN
  ,
  output logic [31:0]        retired_cnt,
  output logic [15:0]        illegal_cnt
`endif
);

  state_t state;
  ctrl_t  ctrl_q;
  ctrl_t  dec_ctrl;
  logic   dec_legal;
  logic   legal_q;
  logic   br_q;
  logic   in_flight;

  alu_seq_decoder u_decoder (
    .instr (instr),
    .ctrl  (dec_ctrl),
    .legal (dec_legal)
  );

  // Sequencer state, captured controls and the registered branch pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      ctrl_q  <= '0;
      legal_q <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      br_q <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ctrl_q  <= dec_ctrl;
            legal_q <= dec_legal;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (!legal_q) begin
            state <= IDLE;
          end else if (ctrl_q.wb) begin
            state <= WB;
          end else if (ctrl_q.mem) begin
            state <= MEM;
          end else begin
            state <= IDLE;
            br_q  <= Zero;
          end
        end
        WB:      state <= IDLE;
        MEM:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Captured controls are only visible while an instruction is in flight.
  assign in_flight    = (state != IDLE);
  assign instr_ready  = (state == IDLE);
  assign busy         = ~instr_ready;
  assign ALUSrc       = in_flight & ctrl_q.alu_src;
  assign ALUControl   = in_flight ? ctrl_q.alu_control : 3'b000;
  assign A1           = in_flight ? A_WIDTH'(ctrl_q.a1) : '0;
  assign A2           = in_flight ? A_WIDTH'(ctrl_q.a2) : '0;
  assign A3           = in_flight ? A_WIDTH'(ctrl_q.a3) : '0;
  assign ImmExt       = in_flight ? D_WIDTH'(ctrl_q.imm) : '0;
  assign RegWrite     = (state == WB) && (ctrl_q.a3 != '0);
  assign ResultSrc    = (state == WB) && ctrl_q.result_src;
  assign MemWrite     = (state == MEM);
  assign illegal      = (state == EXEC) && !legal_q;
  assign branch_taken = br_q;

`ifdef ALUSEQ_PERF_CNT_EN
  logic retire_evt;

  assign retire_evt = (state == WB) || (state == MEM) ||
                      ((state == EXEC) && legal_q && !ctrl_q.wb && !ctrl_q.mem);

  // Free-running wrap-around counters of retired and illegal instructions.
  always_ff @(posedge CLK) begin
    if (RST) begin
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      if (retire_evt) retired_cnt <= retired_cnt + 32'd1;
      if (illegal)    illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`else
  // Counters absent in this build; no extra state.
`endif

endmodule
